// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit multicycle datapath control path:
//   - instruction opcodes (IR[15:12])
//   - ALUop encodings, shared with the ALU control decoder
//   - ALUSrcB and PCSource mux-select encodings
//   - the main control FSM state enum
//   - is_legal_op(): opcode legality helper used by the decoder
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_BEQ   = 4'd3;
  localparam logic [3:0] OP_BNE   = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_ORI   = 4'd6;
  localparam logic [3:0] OP_J     = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // ALUop (to ALU control decoder)
  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;
  localparam logic [1:0] ALUOP_OR   = 2'd3;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REGB  = 2'd0;
  localparam logic [1:0] SRCB_ONE   = 2'd1;
  localparam logic [1:0] SRCB_SEXT  = 2'd2;
  localparam logic [1:0] SRCB_ZEXT  = 2'd3;

  // PCSource select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_ADDI,
    S_EXEC_ORI,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for the 16-bit multicycle datapath. Sequences fetch,
// decode, execute, memory and write-back cycles, waits on mem_ready in the
// memory-access states, and counts retired instructions.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   opcode[3:0]        IR[15:12], sampled in DECODE and MEM_ADDR
//   zero               ALU zero flag (consumed by datapath branch gating)
//   mem_ready          memory read/write completion
//   PCWrite .. ALUSrcA datapath enables and 1-bit mux selects
//   ALUSrcB[1:0]       ALU B source select
//   ALUop[1:0]         operation class for the ALU control decoder
//   PCSource[1:0]      PC source select
//   illegal_op         one-cycle pulse in DECODE for an undefined opcode
//   halted             high while in HALT
//   instr_count        retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t            state_q, state_d;
  logic              bne_q, bne_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire;

  // The branch decision (zero vs. BranchNE) is resolved in the datapath's
  // PC write gating; the control FSM itself does not branch on it.
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    bne_d   = bne_q;
    unique case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // Branch flavour is latched here so BRANCH does not re-read opcode.
        bne_d = (opcode == OP_BNE);
        unique case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_EXEC_ADDI;
          OP_ORI:        state_d = S_EXEC_ORI;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_EXEC_ADDI: state_d = S_I_WB;
      S_EXEC_ORI:  state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Retirement: every transition back into FETCH except from DECODE
  // (illegal opcode) counts one instruction.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WRITE:                                retire = mem_ready;
      default:                                    retire = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      bne_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUop       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_SEXT;
        illegal_op = ~is_legal_op(opcode);
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_FUNC;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_ADDI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      S_EXEC_ORI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_ZEXT;
        ALUop   = ALUOP_OR;
      end
      S_I_WB:      RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNE    = bne_q;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = cnt_q;

endmodule
